// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the multiplexed-display stopwatch.
package stopwatch_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FULL  = 2'd3
    } sw_state_e;

    // Active-low patterns, dp off; entry i is the glyph for digit i.
    localparam logic [9:0][7:0] SEG_PAT = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder; codes above 9 blank, dp_i lights bit 7.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    input  logic             dp_i,
    output logic [7:0]       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (bcd_i == BCD_W'(i)) seg_o = SEG_PAT[i];
        end
        if (dp_i) seg_o[7] = 1'b0;
    end

endmodule

// File: rtl/stopwatch_mux_disp.sv
// BCD stopwatch with run/pause/clear control and a scanned 7-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros above the decimal point.
module stopwatch_mux_disp
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 10,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int DP_DIGIT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_start,
    input  logic                          btn_clear,
    output logic                          running,
    output logic                          overflow,
    output logic [BCD_W*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [7:0]                    seg
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW       = $clog2(NUM_DIGITS);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    sw_state_e                          state_q, state_d;
    logic [TW-1:0]                      tdiv_q, tdiv_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]   digits_q, digits_d, digits_inc;
    logic                               carry_out, tick;

    logic [SW-1:0]                      sdiv_q, sdiv_d;
    logic                               scan_en;
    logic [IW-1:0]                      idx_q, idx_d, idx_nx;
    logic [NUM_DIGITS-1:0]              an_q, an_d;
    logic [7:0]                         seg_q, seg_d, seg_dec;
    logic [BCD_W-1:0]                   disp_code;
    logic                               disp_dp, blank;

    // Ripple-carry decimal increment; carry_out set means every digit was 9.
    always_comb begin
        digits_inc = digits_q;
        carry_out  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry_out) begin
                if (digits_q[i] == BCD_W'(9)) begin
                    digits_inc[i] = '0;
                end else begin
                    digits_inc[i] = digits_q[i] + 1'b1;
                    carry_out     = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tdiv_d   = tdiv_q;
        digits_d = digits_q;
        tick     = 1'b0;
        if (btn_clear) begin
            state_d  = ST_IDLE;
            tdiv_d   = '0;
            digits_d = '0;
        end else begin
            if (state_q == ST_RUN) begin
                if (tdiv_q == TICK_LAST) begin
                    tdiv_d = '0;
                    tick   = 1'b1;
                end else begin
                    tdiv_d = tdiv_q + 1'b1;
                end
            end
            if (tick && !carry_out) digits_d = digits_inc;
            // Overflow beats a coincident start so FULL is never skipped.
            if (tick && carry_out) begin
                state_d = ST_FULL;
            end else if (btn_start) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = state_q;
                endcase
            end
        end
    end

    assign scan_en = (sdiv_q == SCAN_LAST);
    assign idx_nx  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_nx) && digits_q[i] != '0) upper_zero = 1'b0;
        end
        blank = upper_zero && (int'(idx_nx) > DP_DIGIT);
    end
`else
    assign blank = 1'b0;
`endif

    // Blanking reuses the decoder's out-of-range code path.
    assign disp_code = blank ? BCD_W'(4'hF) : digits_q[idx_nx];
    assign disp_dp   = (int'(idx_nx) == DP_DIGIT);

    seg7_decode u_dec (
        .bcd_i (disp_code),
        .dp_i  (disp_dp),
        .seg_o (seg_dec)
    );

    always_comb begin
        sdiv_d = scan_en ? '0 : sdiv_q + 1'b1;
        idx_d  = idx_q;
        an_d   = an_q;
        seg_d  = seg_q;
        if (scan_en) begin
            idx_d = idx_nx;
            an_d  = NUM_DIGITS'(1) << idx_nx;
            seg_d = seg_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tdiv_q   <= '0;
            digits_q <= '0;
            sdiv_q   <= '0;
            idx_q    <= IDX_LAST;
            an_q     <= '0;
            seg_q    <= SEG_BLANK;
        end else begin
            state_q  <= state_d;
            tdiv_q   <= tdiv_d;
            digits_q <= digits_d;
            sdiv_q   <= sdiv_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign running  = (state_q == ST_RUN);
    assign overflow = (state_q == ST_FULL);
    assign digits   = digits_q;
    assign an       = an_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_stopwatch_mux_disp.sv
// Bench for stopwatch_mux_disp: integer-count reference model plus directed scenarios.
module tb_stopwatch_mux_disp;

    localparam int N    = 4;
    localparam int DP   = 1;
    localparam int TDIV = 10;
    localparam int SDIV = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FULL = 3;

    logic        clk, rst, btn_start, btn_clear;
    logic        running, overflow;
    logic [15:0] digits;
    logic [3:0]  an;
    logic [7:0]  seg;

    logic        f_start, f_clear, f_running, f_overflow;
    logic [15:0] f_digits;
    logic [3:0]  f_an;
    logic [7:0]  f_seg;

    stopwatch_mux_disp #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250),
                         .NUM_DIGITS(N), .DP_DIGIT(DP)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
        .running(running), .overflow(overflow), .digits(digits), .an(an), .seg(seg));

    // Ticks every RUN cycle so overflow is reachable within a short run.
    stopwatch_mux_disp #(.CLK_HZ(1000), .TICK_HZ(1000), .SCAN_HZ(250),
                         .NUM_DIGITS(N), .DP_DIGIT(DP)) dut_fast (
        .clk(clk), .rst(rst), .btn_start(f_start), .btn_clear(f_clear),
        .running(f_running), .overflow(f_overflow), .digits(f_digits), .an(f_an), .seg(f_seg));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int m_st, m_cnt, m_ph, m_sc, m_idx, m_an;
    logic [7:0] m_seg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int p10(input int k);
        int v = 1;
        for (int i = 0; i < k; i++) v = v * 10;
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int cnt);
        logic [15:0] r = '0;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'((cnt / p10(i)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int idx, input int cnt);
        logic [7:0] s;
        s = pat[(cnt / p10(idx)) % 10];
        if (idx == DP) s[7] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > DP && cnt < p10(idx)) s = 8'hFF;
`endif
        return s;
    endfunction

    function void model_step(input bit s, input bit c, input bit r);
        bit tk, ovf;
        tk = 1'b0;
        ovf = 1'b0;
        if (r) begin
            m_st = M_IDLE; m_cnt = 0; m_ph = 0; m_sc = 0;
            m_idx = N - 1; m_an = 0; m_seg = 8'hFF;
            return;
        end
        // Display samples the count as it stood before this edge.
        if (m_sc == SDIV - 1) begin
            m_sc  = 0;
            m_idx = (m_idx + 1) % N;
            m_an  = 1 << m_idx;
            m_seg = exp_seg(m_idx, m_cnt);
        end else begin
            m_sc++;
        end
        if (c) begin
            m_st = M_IDLE; m_cnt = 0; m_ph = 0;
        end else begin
            if (m_st == M_RUN) begin
                m_ph++;
                if (m_ph == TDIV) begin m_ph = 0; tk = 1'b1; end
            end
            if (tk) begin
                if (m_cnt == p10(N) - 1) ovf = 1'b1;
                else m_cnt++;
            end
            if (ovf) m_st = M_FULL;
            else if (s) begin
                if (m_st == M_IDLE || m_st == M_PAUSE) m_st = M_RUN;
                else if (m_st == M_RUN) m_st = M_PAUSE;
            end
        end
    endfunction

    task automatic step(input bit s, input bit c, input bit r);
        btn_start = s;
        btn_clear = c;
        rst       = r;
        @(posedge clk);
        model_step(s, c, r);
        #1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        rst       = 1'b0;
        chk("digits",   32'(digits),   32'(to_bcd(m_cnt)));
        chk("running",  32'(running),  32'(m_st == M_RUN));
        chk("overflow", 32'(overflow), 32'(m_st == M_FULL));
        chk("an",       32'(an),       32'(m_an));
        chk("seg",      32'(seg),      32'(m_seg));
    endtask

    initial begin
        int seen;
        rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0;
        f_start = 1'b0; f_clear = 1'b0;
        step(0, 0, 1);
        step(0, 0, 1);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_running", 32'(running), 32'h0);

        // Count-up: 120 run cycles at 10 cycles per tick.
        step(1, 0, 0);
        repeat (120) step(0, 0, 0);
        chk("run120_digits", 32'(digits), 32'h0012);
        chk("run120_running", 32'(running), 32'h1);

        // Sub-tick phase survives a pause.
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (55) step(0, 0, 0);
        step(1, 0, 0);
        repeat (100) step(0, 0, 0);
        chk("pause_hold", 32'(digits), 32'h0005);
        step(1, 0, 0);
        repeat (5) step(0, 0, 0);
        chk("pause_phase", 32'(digits), 32'h0006);

        // Clear and start together: clear wins.
        step(1, 0, 0);
        repeat (37) step(0, 0, 0);
        step(1, 1, 0);
        chk("clr_start_digits", 32'(digits), 32'h0);
        chk("clr_start_running", 32'(running), 32'h0);

        // Reset mid-run beats concurrent buttons.
        step(1, 0, 0);
        for (int k = 0; k < 1000 && m_cnt != 42; k++) step(0, 0, 0);
        chk("reach42", 32'(digits), 32'h0042);
        step(1, 1, 1);
        chk("rstrun_digits", 32'(digits), 32'h0);
        chk("rstrun_an", 32'(an), 32'h0);
        chk("rstrun_seg", 32'(seg), 32'hFF);
        chk("rstrun_running", 32'(running), 32'h0);

        // Scan pattern at 0305.
        step(1, 0, 0);
        for (int k = 0; k < 4000 && m_cnt != 305; k++) step(0, 0, 0);
        step(1, 0, 0);
        chk("reach305", 32'(digits), 32'h0305);
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 0);
            case (an)
                4'b0001: begin chk("scan_d0", 32'(seg), 32'h92); seen |= 1; end
                4'b0010: begin chk("scan_d1", 32'(seg), 32'h40); seen |= 2; end
                4'b0100: begin chk("scan_d2", 32'(seg), 32'hB0); seen |= 4; end
                4'b1000: begin
`ifdef LEADING_ZERO_BLANK_EN
                    chk("scan_d3", 32'(seg), 32'hFF);
`else
                    chk("scan_d3", 32'(seg), 32'hC0);
`endif
                    seen |= 8;
                end
                default: chk("scan_onehot", 32'(an), 32'h1);
            endcase
        end
        chk("scan_all_seen", 32'(seen), 32'hF);

        // Overflow on the fast instance.
        step(0, 1, 0);
        f_start = 1'b1;
        step(0, 0, 0);
        f_start = 1'b0;
        repeat (9990) step(0, 0, 0);
        chk("fast_9990", 32'(f_digits), 32'h9990);
        chk("fast_running", 32'(f_running), 32'h1);
        repeat (9) step(0, 0, 0);
        chk("fast_9999", 32'(f_digits), 32'h9999);
        chk("fast_no_ovf_yet", 32'(f_overflow), 32'h0);
        step(0, 0, 0);
        chk("full_digits", 32'(f_digits), 32'h9999);
        chk("full_overflow", 32'(f_overflow), 32'h1);
        chk("full_running", 32'(f_running), 32'h0);
        f_start = 1'b1;
        step(0, 0, 0);
        f_start = 1'b0;
        repeat (3) step(0, 0, 0);
        chk("full_ign_start", 32'(f_overflow), 32'h1);
        chk("full_ign_digits", 32'(f_digits), 32'h9999);
        f_clear = 1'b1;
        step(0, 0, 0);
        f_clear = 1'b0;
        chk("full_clr_digits", 32'(f_digits), 32'h0);
        chk("full_clr_overflow", 32'(f_overflow), 32'h0);
        chk("full_clr_running", 32'(f_running), 32'h0);

        // Random buttons and occasional reset against the model.
        for (int k = 0; k < 800; k++)
            step($urandom_range(15) == 0, $urandom_range(39) == 0, $urandom_range(299) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
